// File: rtl/omem_pkg.sv
// Shared types and defaults for the output-SRAM writeback block: widths, FSM states,
// error bit positions, the buffered-write entry layout and the address helper.
package omem_pkg;

  localparam int DATA_W           = 64;
  localparam int DST_W            = 4;
  localparam int ADDR_W           = 12;
  localparam int TILE_W           = 8;
  localparam int DEF_TILE_STRIDE  = 16;
  localparam int DEF_FIFO_DEPTH   = 4;

  localparam int ERR_OVF = 0;  // row dropped because the FIFO was full
  localparam int ERR_SEQ = 1;  // row or tile-done seen outside RUN

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  // Global address of a tile-local row; wraps silently at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [TILE_W-1:0] tile_idx,
                                                   input logic [DST_W-1:0]  dst,
                                                   input int unsigned       stride);
    return base + ADDR_W'(32'(tile_idx) * stride) + ADDR_W'(dst);
  endfunction

endpackage

// File: rtl/omem_wb_fifo.sv
// Show-ahead synchronous FIFO for pending OMEM writes; head entry is visible on rdata
// whenever the FIFO is not empty. Push while full succeeds only with a same-cycle pop.
module omem_wb_fifo
  import omem_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     push,
  input  logic                     pop,
  input  fifo_entry_t              wdata,
  output fifo_entry_t              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fifo_entry_t     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/omem_writeback.sv
// Buffers row writes from the MAC row-packer, relocates them to global OMEM addresses
// and issues them over a valid/ready port; tracks tiles per job and signals job completion.
module omem_writeback
  import omem_pkg::*;
#(
  parameter int TILE_STRIDE = DEF_TILE_STRIDE,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [TILE_W-1:0] TILE_NUM,
  input  logic [DATA_W-1:0] OS_DATA,
  input  logic [DST_W-1:0]  OS_DST,
  input  logic              OS_WRITE,
  input  logic              OS_TDONE,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_READY,
  output logic              BUSY,
  output logic              JOB_DONE,
  output logic [1:0]        ERR
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [TILE_W-1:0] tile_num_q;
  logic [TILE_W-1:0] tile_idx_q;

  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  logic              push, pop, full, empty;
  logic [CW-1:0]     count;
  logic              in_run, start_acc, load_out, drop;

  assign in_run    = (state == RUN);
  assign start_acc = (state == IDLE) && START;
  assign push      = in_run && OS_WRITE;
  // The output register may take a new entry when it is idle or being accepted this cycle.
  assign load_out  = !MEM_REQ || MEM_READY;
  assign pop       = load_out && !empty;
  assign drop      = push && full && !pop;

  assign push_entry.addr = calc_addr(base_q, tile_idx_q, OS_DST, TILE_STRIDE);
  assign push_entry.data = OS_DATA;

  omem_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    state_nx = state;
    BUSY     = 1'b0;
    JOB_DONE = 1'b0;
    unique case (state)
      IDLE:  if (START) state_nx = RUN;
      RUN: begin
        BUSY = 1'b1;
        if (tile_idx_q == tile_num_q) state_nx = DRAIN;
      end
      DRAIN: begin
        BUSY = 1'b1;
        if ((count == '0) && !MEM_REQ) state_nx = DONE;
      end
      DONE: begin
        JOB_DONE = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      base_q     <= '0;
      tile_num_q <= '0;
      tile_idx_q <= '0;
      ERR        <= '0;
    end else begin
      state <= state_nx;
      if (start_acc) begin
        base_q     <= BASE_ADDR;
        tile_num_q <= TILE_NUM;
        tile_idx_q <= '0;
        ERR        <= '0;
      end else if (in_run && OS_TDONE) begin
        tile_idx_q <= tile_idx_q + TILE_W'(1);
      end
      if (drop)                             ERR[ERR_OVF] <= 1'b1;
      if (!in_run && (OS_WRITE || OS_TDONE)) ERR[ERR_SEQ] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      MEM_REQ   <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else if (load_out) begin
      MEM_REQ <= !empty;
      if (!empty) begin
        MEM_ADDR  <= head.addr;
        MEM_WDATA <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_omem_writeback.sv
// Randomized scoreboard bench for omem_writeback: a reference model predicts every SRAM
// write, overflow drop and error flag; a monitor compares each accepted write in order.
module tb_omem_writeback;

  localparam int DEPTH  = 4;
  localparam int STRIDE = 16;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        START = 1'b0;
  logic [11:0] BASE_ADDR = '0;
  logic [7:0]  TILE_NUM = '0;
  logic [63:0] OS_DATA = '0;
  logic [3:0]  OS_DST = '0;
  logic        OS_WRITE = 1'b0;
  logic        OS_TDONE = 1'b0;
  logic        MEM_READY = 1'b0;
  logic        MEM_REQ;
  logic [11:0] MEM_ADDR;
  logic [63:0] MEM_WDATA;
  logic        BUSY;
  logic        JOB_DONE;
  logic [1:0]  ERR;

  omem_writeback #(.TILE_STRIDE(STRIDE), .FIFO_DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .START     (START),
    .BASE_ADDR (BASE_ADDR),
    .TILE_NUM  (TILE_NUM),
    .OS_DATA   (OS_DATA),
    .OS_DST    (OS_DST),
    .OS_WRITE  (OS_WRITE),
    .OS_TDONE  (OS_TDONE),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_READY (MEM_READY),
    .BUSY      (BUSY),
    .JOB_DONE  (JOB_DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];
  int  outstanding = 0;  // rows accepted by the block but not yet written to SRAM
  int  jd_count = 0;
  bit  in_run = 1'b0;
  int  m_base = 0;
  int  m_tile = 0;
  bit  exp_ovf = 1'b0;
  bit  exp_seq = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic bit rdy(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  // One clock of stimulus; the model decides acceptance and address from its own job state.
  task automatic cyc(input bit wr, input logic [3:0] dst, input logic [63:0] data,
                     input bit tdone, input bit ready, input bit st);
    bit hs;
    bit acc;
    @(posedge CLK);
    #1;
    START     = st;
    OS_WRITE  = wr;
    OS_DST    = dst;
    OS_DATA   = data;
    OS_TDONE  = tdone;
    MEM_READY = ready;
    hs  = MEM_REQ && ready;
    acc = 1'b0;
    if (wr) begin
      if (!in_run) exp_seq = 1'b1;
      else if (outstanding - int'(hs) < DEPTH + 1) begin
        exp_q.push_back('{addr: 12'((m_base + m_tile * STRIDE + int'(dst)) % 4096), data: data});
        acc = 1'b1;
      end else exp_ovf = 1'b1;
    end
    if (tdone) begin
      if (in_run) m_tile++;
      else exp_seq = 1'b1;
    end
    outstanding += int'(acc) - int'(hs);
  endtask

  task automatic start_job(input string tag, input int base, input int tiles);
    jd_count  = 0;
    BASE_ADDR = 12'(base);
    TILE_NUM  = 8'(tiles);
    cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    in_run  = 1'b1;
    m_base  = base;
    m_tile  = 0;
    exp_ovf = 1'b0;
    exp_seq = 1'b0;
    cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check({tag, "_busy_run"}, 64'(BUSY), 64'd1);
    check({tag, "_err_clr"}, 64'(ERR), 64'd0);
  endtask

  task automatic finish_job(input string tag);
    int n;
    n = 0;
    while (jd_count == 0 && n < 300) begin
      cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    if (jd_count == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no JOB_DONE expected one within 300 cycles", tag);
    end
    repeat (3) cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check({tag, "_jobdone_cnt"}, 64'(jd_count), 64'd1);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_err"}, 64'(ERR), 64'({exp_seq, exp_ovf}));
    check({tag, "_busy_idle"}, 64'(BUSY), 64'd0);
  endtask

  task automatic run_job(input string tag, input int base, input int tiles, input int rows,
                         input bit seq_dst, input int ready_pct, input int stall, input bit combine);
    start_job(tag, base, tiles);
    for (int t = 0; t < tiles; t++) begin
      for (int r = 0; r < rows; r++) begin
        cyc(1'b1, seq_dst ? 4'(r) : 4'($urandom_range(15, 0)), {$urandom(), $urandom()},
            combine && (r == rows - 1), rdy(ready_pct), 1'b0);
      end
      if (!(combine && rows > 0)) cyc(1'b0, 4'd0, 64'd0, 1'b1, rdy(ready_pct), 1'b0);
    end
    in_run = 1'b0;
    repeat (stall) cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    finish_job(tag);
  endtask

  // Monitor: compares every accepted write against the head of the expected queue.
  bit          prev_stall = 1'b0;
  logic [11:0] prev_addr;
  logic [63:0] prev_data;
  wr_t         got_e;
  initial begin
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_req", 64'(MEM_REQ), 64'd1);
          check("hold_addr", 64'(MEM_ADDR), 64'(prev_addr));
          check("hold_data", MEM_WDATA, prev_data);
        end
        if (JOB_DONE) jd_count++;
        if (MEM_REQ && MEM_READY) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr 0x%0h expected no write", MEM_ADDR);
          end else begin
            got_e = exp_q.pop_front();
            check("wr_addr", 64'(MEM_ADDR), 64'(got_e.addr));
            check("wr_data", MEM_WDATA, got_e.data);
          end
        end
        prev_stall = MEM_REQ && !MEM_READY;
        prev_addr  = MEM_ADDR;
        prev_data  = MEM_WDATA;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_req", 64'(MEM_REQ), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_jobdone", 64'(JOB_DONE), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    #1 RSTN = 1'b1;

    // Two tiles of four rows at full throughput.
    run_job("t1", 'h100, 2, 4, 1'b1, 100, 0, 1'b0);
    // SRAM stalled while four rows arrive; nothing may be lost.
    run_job("t2", 'h040, 1, 4, 1'b1, 0, 6, 1'b0);
    // One entry sits in the output register, so the sixth stalled row overflows.
    run_job("t3", 'h200, 1, 6, 1'b1, 0, 2, 1'b0);
    run_job("t3b", 'h280, 1, 2, 1'b1, 100, 0, 1'b1);
    // Address wrap across the top of the OMEM space.
    run_job("t4", 'hFF8, 2, 4, 1'b1, 100, 0, 1'b0);

    // Zero-tile job: RUN, DRAIN, then DONE on consecutive cycles.
    start_job("t5", 'h300, 0);
    in_run = 1'b0;
    check("t5_jd_run", 64'(JOB_DONE), 64'd0);
    cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("t5_jd_drain", 64'(JOB_DONE), 64'd0);
    cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("t5_jd_done", 64'(JOB_DONE), 64'd1);
    finish_job("t5");
    cyc(1'b1, 4'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    check("t5_idle_err", 64'(ERR), 64'({exp_seq, exp_ovf}));
    check("t5_idle_req", 64'(MEM_REQ), 64'd0);

    // Randomized jobs with random back-pressure and tile-done merging.
    for (int j = 0; j < 8; j++) begin
      run_job("rnd", int'($urandom_range(4095, 0)), int'($urandom_range(3, 1)),
              int'($urandom_range(6, 1)), 1'b0, int'($urandom_range(100, 20)), 0,
              1'($urandom_range(1, 0)));
    end

    // Reset in DRAIN with a write pending.
    start_job("t6", 'h200, 1);
    for (int r = 0; r < 3; r++) cyc(1'b1, 4'(r), {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    in_run = 1'b0;
    repeat (3) cyc(1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check("t6_req_before", 64'(MEM_REQ), 64'd1);
    check("t6_busy_before", 64'(BUSY), 64'd1);
    #2 RSTN = 1'b0;
    #1;
    check("t6_req_rst", 64'(MEM_REQ), 64'd0);
    check("t6_busy_rst", 64'(BUSY), 64'd0);
    exp_q.delete();
    outstanding = 0;
    repeat (2) @(posedge CLK);
    #2 RSTN = 1'b1;
    run_job("t6post", 'h100, 2, 4, 1'b1, 100, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
